// File: rtl/regfile_pkg.sv
// Shared constants, the address-width helper and the port records for the
// multi-ported register file with pending-write scoreboard.
package regfile_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_NREGS  = 32;
  localparam int DEF_NRD    = 2;
  localparam int DEF_NWR    = 2;
  localparam int DEF_BYPASS = 1;
  localparam int DEF_CNTW   = 2;

  // Index width for n registers; never below 1 so a 2-entry file still has an address bit.
  function automatic int calc_aw(input int n);
    int aw;
    aw = 1;
    while ((1 << aw) < n) aw++;
    return aw;
  endfunction

  localparam int DEF_AW = calc_aw(DEF_NREGS);

  // One write port as seen in the default configuration.
  typedef struct packed {
    logic                en;
    logic [DEF_AW-1:0]   addr;
    logic [DEF_XLEN-1:0] data;
  } wr_port_t;

  // One read port: request index plus the data/busy it answers with.
  typedef struct packed {
    logic [DEF_AW-1:0]   addr;
    logic [DEF_XLEN-1:0] data;
    logic                busy;
  } rd_port_t;

endpackage

// File: rtl/regfile_sb.sv
// Pending-write scoreboard: one saturating counter per register, raised by a
// reserve and lowered by every write port that lands on that register.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int NREGS = DEF_NREGS,
  parameter  int NRD   = DEF_NRD,
  parameter  int NWR   = DEF_NWR,
  parameter  int CNTW  = DEF_CNTW,
  localparam int AW    = calc_aw(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst_enr,
  input  logic [NRD-1:0][AW-1:0]  rd_addr,
  output logic [NRD-1:0]          rd_busy,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR-1:0][AW-1:0]  wr_addr,
  input  logic                    rsv_en,
  input  logic [AW-1:0]           rsv_addr,
  output logic                    rsv_ovf,
  output logic                    all_idle
);

  localparam int CMAX = (1 << CNTW) - 1;

  logic [NREGS-1:0][CNTW-1:0] cnt_q, cnt_d;
  logic                       rsv_ovf_q, rsv_ovf_d;

  // Next count per register: +reserve -writes, floored at 0; a reserve that
  // would pass the ceiling is dropped and flagged instead of wrapping.
  always_comb begin
    int  nxt;
    int  nwr;
    logic hit;
    nxt       = 0;
    nwr       = 0;
    hit       = 1'b0;
    cnt_d     = cnt_q;
    rsv_ovf_d = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      hit = rsv_en && (rsv_addr == AW'(r));
      nwr = 0;
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && (wr_addr[w] == AW'(r))) nwr++;
      nxt = int'(cnt_q[r]) + (hit ? 1 : 0) - nwr;
      if (nxt < 0) nxt = 0;
      if (nxt > CMAX) begin
        nxt       = CMAX;
        rsv_ovf_d = 1'b1;
      end
      cnt_d[r] = CNTW'(nxt);
    end
    cnt_d[0] = '0;
  end

  // Counter and overflow-pulse state; reset discards all reservations.
  always_ff @(posedge clk or posedge rst_enr) begin
    if (rst_enr) begin
      cnt_q     <= '0;
      rsv_ovf_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsv_ovf_q <= rsv_ovf_d;
    end
  end

  // Busy/idle look only at registered counts, never at same-cycle traffic.
  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) rd_busy[p] = (cnt_q[rd_addr[p]] != '0);
  end

  assign all_idle = ~|cnt_q;
  assign rsv_ovf  = rsv_ovf_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file: combinational reads with optional write
// bypass, edge-triggered writes (highest port wins), hardwired-zero x0, and a
// pending-write scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN   = DEF_XLEN,
  parameter  int NREGS  = DEF_NREGS,
  parameter  int NRD    = DEF_NRD,
  parameter  int NWR    = DEF_NWR,
  parameter  int BYPASS = DEF_BYPASS,
  parameter  int CNTW   = DEF_CNTW,
  localparam int AW     = calc_aw(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst_enr,
  input  logic [NRD-1:0][AW-1:0]  rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]          rd_busy,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR-1:0][AW-1:0]  wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic                    rsv_en,
  input  logic [AW-1:0]           rsv_addr,
  output logic                    rsv_ovf,
  output logic                    all_idle
);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;

  // Apply writes in ascending port order so the last port overrides earlier ones.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && (wr_addr[w] != '0)) regs_d[wr_addr[w]] = wr_data[w];
    regs_d[0] = '0;
  end

  // Storage; reset clears every entry without waiting for a clock.
  always_ff @(posedge clk or posedge rst_enr) begin
    if (rst_enr) regs_q <= '0;
    else         regs_q <= regs_d;
  end

  // Read muxes: stored value, then forwarded write data (same priority as
  // storage), with x0 forced to zero last. Forwarding is off during reset
  // because those writes will never land.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      if ((BYPASS != 0) && !rst_enr)
        for (int w = 0; w < NWR; w++)
          if (wr_en[w] && (wr_addr[w] == rd_addr[p])) rd_data[p] = wr_data[w];
      if (rd_addr[p] == '0) rd_data[p] = '0;
    end
  end

  regfile_sb #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .CNTW  (CNTW)
  ) u_sb (
    .clk      (clk),
    .rst_enr  (rst_enr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ovf  (rsv_ovf),
    .all_idle (all_idle)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a vector table applied once per cycle plus
// hand-written reset sequences. A second instance with BYPASS=0 shares inputs.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int AW = DEF_AW;

  logic                 clk = 1'b0;
  logic                 rst_enr = 1'b1;
  logic [1:0][AW-1:0]   rd_addr;
  logic [1:0][31:0]     rd_data, nb_rd_data;
  logic [1:0]           rd_busy, nb_rd_busy;
  logic [1:0]           wr_en;
  logic [1:0][AW-1:0]   wr_addr;
  logic [1:0][31:0]     wr_data;
  logic                 rsv_en;
  logic [AW-1:0]        rsv_addr;
  logic                 rsv_ovf, nb_rsv_ovf, all_idle, nb_all_idle;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .rst_enr(rst_enr), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ovf(rsv_ovf), .all_idle(all_idle)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_enr(rst_enr), .rd_addr(rd_addr), .rd_data(nb_rd_data),
    .rd_busy(nb_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ovf(nb_rsv_ovf), .all_idle(nb_all_idle)
  );

  typedef struct {
    wr_port_t    w0, w1;
    logic        rsv;
    logic [AW-1:0] ra;
    rd_port_t    r0, r1;
    logic        ovf, idle;
    logic [31:0] nb0;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int w0e, int w0a, int w0d, int w1e, int w1a, int w1d,
                              int rs, int ra, int r0a, int r1a, int e0, int e1,
                              int eb0, int eb1, int eovf, int eidle, int enb);
    vec_t v;
    v.w0.en = (w0e != 0); v.w0.addr = AW'(w0a); v.w0.data = w0d;
    v.w1.en = (w1e != 0); v.w1.addr = AW'(w1a); v.w1.data = w1d;
    v.rsv = (rs != 0); v.ra = AW'(ra);
    v.r0.addr = AW'(r0a); v.r0.data = e0; v.r0.busy = (eb0 != 0);
    v.r1.addr = AW'(r1a); v.r1.data = e1; v.r1.busy = (eb1 != 0);
    v.ovf = (eovf != 0); v.idle = (eidle != 0); v.nb0 = enb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic quiet();
    wr_en = '0; wr_addr = '0; wr_data = '0; rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic drive(input vec_t v);
    wr_en      = {v.w1.en, v.w0.en};
    wr_addr[0] = v.w0.addr; wr_data[0] = v.w0.data;
    wr_addr[1] = v.w1.addr; wr_data[1] = v.w1.data;
    rsv_en     = v.rsv;     rsv_addr   = v.ra;
    rd_addr[0] = v.r0.addr; rd_addr[1] = v.r1.addr;
  endtask

  initial begin
    quiet();
    rd_addr = '0;
    //        w0e w0a w0d           w1e w1a w1d     rs ra r0a r1a exp0          exp1     b0 b1 ovf idle nb0
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       0, 0, 5, 0, 0,            0,       0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 5, 32'hDEADBEEF,0, 0, 0,       0, 0, 5, 0, 32'hDEADBEEF, 0,       0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 32'h55,      0, 0, 0,       0, 0, 5, 0, 32'hDEADBEEF, 0,       0, 0, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       0, 0, 0, 5, 0,   32'hDEADBEEF,     0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,           1, 7, 32'h99,  0, 0, 7, 0, 32'h99,       0,       0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,           1, 7, 32'h1234,0, 0, 7, 7, 32'h1234, 32'h1234,    0, 0, 0, 1, 32'h99));
    vecs.push_back(mk(1, 3, 32'hA,       1, 3, 32'hB,   0, 0, 3, 7, 32'hB,    32'h1234,    0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       0, 0, 3, 7, 32'hB,    32'h1234,    0, 0, 0, 1, 32'hB));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       1, 9, 9, 0, 0,            0,       0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       1, 9, 9, 0, 0,            0,       1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       1, 9, 9, 9, 0,            0,       1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       1, 9, 9, 0, 0,            0,       1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       0, 0, 9, 0, 0,            0,       1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 9, 32'h11,      0, 0, 0,       0, 0, 9, 0, 32'h11,       0,       1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 9, 32'h22,      0, 0, 0,       0, 0, 9, 0, 32'h22,       0,       1, 0, 0, 0, 32'h11));
    vecs.push_back(mk(0, 0, 0,           1, 9, 32'h33,  0, 0, 9, 0, 32'h33,       0,       1, 0, 0, 0, 32'h22));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       0, 0, 9, 0, 32'h33,       0,       0, 0, 0, 1, 32'h33));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       1, 4, 4, 0, 0,            0,       0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 4, 32'h44,      0, 0, 0,       1, 4, 4, 0, 32'h44,       0,       1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       0, 0, 4, 0, 32'h44,       0,       1, 0, 0, 0, 32'h44));
    vecs.push_back(mk(1, 4, 32'h45,      0, 0, 0,       0, 0, 4, 0, 32'h45,       0,       1, 0, 0, 0, 32'h44));
    vecs.push_back(mk(1, 4, 32'h46,      0, 0, 0,       0, 0, 4, 0, 32'h46,       0,       0, 0, 0, 1, 32'h45));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       0, 0, 4, 0, 32'h46,       0,       0, 0, 0, 1, 32'h46));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       1, 4, 4, 0, 32'h46,       0,       0, 0, 0, 1, 32'h46));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       1, 4, 4, 0, 32'h46,       0,       1, 0, 0, 0, 32'h46));
    vecs.push_back(mk(1, 4, 32'h50,      1, 4, 32'h51,  0, 0, 4, 0, 32'h51,       0,       1, 0, 0, 0, 32'h46));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       0, 0, 4, 0, 32'h51,       0,       0, 0, 0, 1, 32'h51));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       1, 0, 0, 0, 0,            0,       0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,           0, 0, 0,       0, 0, 0, 0, 0,            0,       0, 0, 0, 1, 0));

    // Reset state, sampled while reset is still held.
    #2;
    chk("rst_idle", 32'(all_idle), 32'd1);
    chk("rst_ovf", 32'(rsv_ovf), 32'd0);
    @(negedge clk);
    rst_enr = 1'b0;

    // Inputs change on the falling edge; outputs checked 1 time unit later,
    // well before the rising edge that commits this vector.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d rd0", i), rd_data[0], vecs[i].r0.data);
      chk($sformatf("v%0d rd1", i), rd_data[1], vecs[i].r1.data);
      chk($sformatf("v%0d busy0", i), 32'(rd_busy[0]), 32'(vecs[i].r0.busy));
      chk($sformatf("v%0d busy1", i), 32'(rd_busy[1]), 32'(vecs[i].r1.busy));
      chk($sformatf("v%0d ovf", i), 32'(rsv_ovf), 32'(vecs[i].ovf));
      chk($sformatf("v%0d idle", i), 32'(all_idle), 32'(vecs[i].idle));
      chk($sformatf("v%0d nb_rd0", i), nb_rd_data[0], vecs[i].nb0);
      chk($sformatf("v%0d nb_busy0", i), 32'(nb_rd_busy[0]), 32'(vecs[i].r0.busy));
      chk($sformatf("v%0d nb_ovf", i), 32'(nb_rsv_ovf), 32'(vecs[i].ovf));
      chk($sformatf("v%0d nb_idle", i), 32'(nb_all_idle), 32'(vecs[i].idle));
    end

    // Saturate x9 (fourth reserve overflows), then hit async reset mid-cycle.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      quiet();
      rsv_en = 1'b1; rsv_addr = AW'(9);
    end
    @(negedge clk);
    quiet();
    rd_addr[0] = AW'(5); rd_addr[1] = AW'(9);
    #1;
    chk("pre_rst x5", rd_data[0], 32'hDEADBEEF);
    chk("pre_rst busy9", 32'(rd_busy[1]), 32'd1);
    chk("pre_rst ovf", 32'(rsv_ovf), 32'd1);
    chk("pre_rst idle", 32'(all_idle), 32'd0);
    #1 rst_enr = 1'b1;
    #1;
    chk("async x5", rd_data[0], 32'd0);
    chk("async nb x5", nb_rd_data[0], 32'd0);
    chk("async busy9", 32'(rd_busy[1]), 32'd0);
    chk("async ovf", 32'(rsv_ovf), 32'd0);
    chk("async idle", 32'(all_idle), 32'd1);

    // Traffic while reset is held must be dropped.
    @(negedge clk);
    wr_en[0] = 1'b1; wr_addr[0] = AW'(5); wr_data[0] = 32'h77;
    rsv_en = 1'b1; rsv_addr = AW'(9);
    @(posedge clk);
    #1;
    chk("in_rst x5", rd_data[0], 32'd0);
    chk("in_rst busy9", 32'(rd_busy[1]), 32'd0);
    @(negedge clk);
    quiet();
    rst_enr = 1'b0;
    #1;
    chk("post_rst x5", rd_data[0], 32'd0);
    chk("post_rst idle", 32'(all_idle), 32'd1);

    // First edge after release accepts a write and a reserve.
    wr_en[0] = 1'b1; wr_addr[0] = AW'(5); wr_data[0] = 32'h77;
    rsv_en = 1'b1; rsv_addr = AW'(9);
    @(posedge clk);
    #1;
    quiet();
    #1;
    chk("first x5", rd_data[0], 32'h77);
    chk("first busy9", 32'(rd_busy[1]), 32'd1);
    chk("first idle", 32'(all_idle), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
